mem_noc_rr_arb: RTL and testbench

MEM_NOC_RR_ARB -- requirements
Module: mem_noc_rr_arb

---
 rtl/urv_cfg.sv | 15 +
 rtl/urv_typedef.sv | 21 ++
 rtl/mem_noc_tag_fifo.sv | 85 ++++++++
 rtl/stdffrv.sv | 28 ++
 rtl/stdffrve.sv | 29 ++
 rtl/mem_noc_rr_arb.sv | 152 +++++++++++++++
 tb/tb_mem_noc_rr_arb.sv | 293 +++++++++++++++++++++++++++++
 7 files changed

// File: rtl/urv_cfg.sv
`default_nettype none
// ============================================================================
// Package     : urv_cfg
// Description : Shared configuration constants for the mem noc fabric.
// Revision    : 1.0 - initial release
// ============================================================================
package urv_cfg;

    // Default depth of the in-flight tag queue (power of two).
    localparam int c_MAX_OUTSTD  = 4;
    // Largest number of masters a single arbiter may serve.
    localparam int c_NUM_MST_MAX = 8;

endpackage : urv_cfg
`default_nettype wire

// File: rtl/urv_typedef.sv
`default_nettype none
// ============================================================================
// Package     : urv_typedef
// Description : Request/response payload types of the mem noc channels.
// Revision    : 1.0 - initial release
// ============================================================================
package urv_typedef;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } mem_resp_t;

endpackage : urv_typedef
`default_nettype wire

// File: rtl/mem_noc_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_noc_tag_fifo
// Description : In-order tag queue recording which master owns each
//               in-flight request. Pointers wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_noc_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    // Occupancy moves only when exactly one of push/pop happens.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + c_CNT_W'(1);
        else if (w_pop && !w_push) w_count_nxt = r_count - c_CNT_W'(1);
    end

    stdffrve #(.WIDTH(c_PTR_W)) u_wr_ptr (
        .clk  (clk),
        .rstn (rstn),
        .i_en (w_push),
        .i_d  (r_wr_ptr + c_PTR_W'(1)),
        .o_q  (r_wr_ptr)
    );

    stdffrve #(.WIDTH(c_PTR_W)) u_rd_ptr (
        .clk  (clk),
        .rstn (rstn),
        .i_en (w_pop),
        .i_d  (r_rd_ptr + c_PTR_W'(1)),
        .o_q  (r_rd_ptr)
    );

    stdffrv #(.WIDTH(c_CNT_W)) u_count (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (w_count_nxt),
        .o_q  (r_count)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        stdffrve #(.WIDTH(WIDTH)) u_entry (
            .clk  (clk),
            .rstn (rstn),
            .i_en (w_push && (r_wr_ptr == c_PTR_W'(gi))),
            .i_d  (i_wdata),
            .o_q  (r_mem[gi])
        );
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : mem_noc_tag_fifo
`default_nettype wire

// File: rtl/stdffrv.sv
`default_nettype none
// ============================================================================
// Module      : stdffrv
// Description : D flop bank with asynchronous active-low reset to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module stdffrv #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture every cycle, reset asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_q <= RESET_VAL;
        else       r_q <= i_d;
    end

    assign o_q = r_q;

endmodule : stdffrv
`default_nettype wire

// File: rtl/stdffrve.sv
`default_nettype none
// ============================================================================
// Module      : stdffrve
// Description : Enabled D flop bank with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stdffrve #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture only when enabled, reset asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     r_q <= RESET_VAL;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule : stdffrve
`default_nettype wire

// File: rtl/mem_noc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_noc_rr_arb
// Description : Round-robin arbiter letting NUM_MST mem noc masters share one
//               slave. Requests and responses pass through combinationally;
//               an in-order tag queue routes responses back to their owners.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_noc_rr_arb
    import urv_cfg::*, urv_typedef::*;
#(
    parameter int NUM_MST    = 4,
    parameter int MAX_OUTSTD = c_MAX_OUTSTD
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic      [NUM_MST-1:0]       mst_req_valid,
    output logic      [NUM_MST-1:0]       mst_req_ready,
    input  mem_req_t  [NUM_MST-1:0]       mst_req,
    output logic      [NUM_MST-1:0]       mst_resp_valid,
    input  logic      [NUM_MST-1:0]       mst_resp_ready,
    output mem_resp_t [NUM_MST-1:0]       mst_resp,
    output logic                          sn_req_valid,
    input  logic                          sn_req_ready,
    output mem_req_t                      sn_req,
    input  logic                          sn_resp_valid,
    output logic                          sn_resp_ready,
    input  mem_resp_t                     sn_resp,
    output logic [$clog2(MAX_OUTSTD):0]   outstd_cnt,
    output logic                          resp_err
);

    localparam int c_IDX_W = $clog2(NUM_MST);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic               r_lock;
    logic [c_IDX_W-1:0] r_lock_idx;
    mem_req_t           r_lock_req;
    logic               r_resp_err;

    logic               w_rr_any;
    logic [c_IDX_W-1:0] w_rr_idx;
    logic               w_gnt_any;
    logic [c_IDX_W-1:0] w_gnt_idx;
    mem_req_t           w_gnt_req;
    logic               w_q_full;
    logic               w_q_empty;
    logic [c_IDX_W-1:0] w_q_head;
    logic               w_req_hs;
    logic               w_resp_hs;

    // Master index 'off' positions after 'base', wrapping at NUM_MST.
    function automatic logic [c_IDX_W-1:0] f_rr_idx(input logic [c_IDX_W-1:0] base,
                                                     input int                 off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_MST) sum = sum - NUM_MST;
        return c_IDX_W'(sum);
    endfunction

    // Search upward from rr_ptr; scanning from the far end keeps the nearest hit.
    always_comb begin
        w_rr_any = 1'b0;
        w_rr_idx = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (mst_req_valid[f_rr_idx(r_rr_ptr, k)]) begin
                w_rr_any = 1'b1;
                w_rr_idx = f_rr_idx(r_rr_ptr, k);
            end
        end
    end

    // A stalled request keeps its master and captured payload until accepted.
    assign w_gnt_any    = r_lock | w_rr_any;
    assign w_gnt_idx    = r_lock ? r_lock_idx : w_rr_idx;
    assign w_gnt_req    = r_lock ? r_lock_req : (w_rr_any ? mst_req[w_rr_idx] : '0);

    assign sn_req_valid = rstn & w_gnt_any & ~w_q_full;
    assign sn_req       = w_gnt_req;
    assign w_req_hs     = sn_req_valid & sn_req_ready;

    // Only the granted master sees ready, and only when a tag slot is free.
    always_comb begin
        mst_req_ready = '0;
        if (rstn && w_gnt_any && !w_q_full) mst_req_ready[w_gnt_idx] = sn_req_ready;
    end

    // Route the slave response to the queue head; with nothing outstanding,
    // swallow it so the slave never stalls on a stray response.
    always_comb begin
        mst_resp_valid = '0;
        mst_resp       = '0;
        sn_resp_ready  = 1'b0;
        if (rstn) begin
            if (w_q_empty) begin
                sn_resp_ready = 1'b1;
            end else begin
                mst_resp_valid[w_q_head] = sn_resp_valid;
                mst_resp[w_q_head]       = sn_resp;
                sn_resp_ready            = mst_resp_ready[w_q_head];
            end
        end
    end

    assign w_resp_hs = sn_resp_valid & sn_resp_ready & ~w_q_empty;

    // Pointer moves just past the master that won the accepted request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         r_rr_ptr <= '0;
        else if (w_req_hs) r_rr_ptr <= f_rr_idx(w_gnt_idx, 1);
    end

    // Lock the grant while the slave back-pressures a valid request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_lock_req <= '0;
        end else if (w_req_hs) begin
            r_lock     <= 1'b0;
        end else if (sn_req_valid) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_gnt_idx;
            r_lock_req <= w_gnt_req;
        end
    end

    // Sticky flag for a response that arrived with no owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                           r_resp_err <= 1'b0;
        else if (sn_resp_valid && w_q_empty) r_resp_err <= 1'b1;
    end

    assign resp_err = r_resp_err;

    mem_noc_tag_fifo #(
        .WIDTH (c_IDX_W),
        .DEPTH (MAX_OUTSTD)
    ) u_tag_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_req_hs),
        .i_pop   (w_resp_hs),
        .i_wdata (w_gnt_idx),
        .o_rdata (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (outstd_cnt)
    );

endmodule : mem_noc_rr_arb
`default_nettype wire

// File: tb/tb_mem_noc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_noc_rr_arb
// Description : Directed self-checking bench for mem_noc_rr_arb (4 masters,
//               4 outstanding).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_noc_rr_arb;
    import urv_typedef::*;

    logic             clk = 1'b0;
    logic             rstn;
    logic      [3:0]  mst_req_valid;
    logic      [3:0]  mst_req_ready;
    mem_req_t  [3:0]  mst_req;
    logic      [3:0]  mst_resp_valid;
    logic      [3:0]  mst_resp_ready;
    mem_resp_t [3:0]  mst_resp;
    logic             sn_req_valid;
    logic             sn_req_ready;
    mem_req_t         sn_req;
    logic             sn_resp_valid;
    logic             sn_resp_ready;
    mem_resp_t        sn_resp;
    logic      [2:0]  outstd_cnt;
    logic             resp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_noc_rr_arb #(.NUM_MST(4), .MAX_OUTSTD(4)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mst_req_valid  (mst_req_valid),
        .mst_req_ready  (mst_req_ready),
        .mst_req        (mst_req),
        .mst_resp_valid (mst_resp_valid),
        .mst_resp_ready (mst_resp_ready),
        .mst_resp       (mst_resp),
        .sn_req_valid   (sn_req_valid),
        .sn_req_ready   (sn_req_ready),
        .sn_req         (sn_req),
        .sn_resp_valid  (sn_resp_valid),
        .sn_resp_ready  (sn_resp_ready),
        .sn_resp        (sn_resp),
        .outstd_cnt     (outstd_cnt),
        .resp_err       (resp_err)
    );

    function automatic mem_req_t mk_req(input int i);
        mem_req_t r;
        r.we    = i[0];
        r.addr  = 16'hA000 + 16'(i);
        r.wdata = 16'h5500 + 16'(i);
        return r;
    endfunction

    function automatic mem_req_t mk_alt(input int i);
        mem_req_t r;
        r.we    = ~i[0];
        r.addr  = 16'hBEE0 + 16'(i);
        r.wdata = 16'h0F0F;
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input int i);
        mem_resp_t r;
        r.err   = (i == 3);
        r.rdata = 16'hE000 + 16'(i);
        return r;
    endfunction

    function automatic logic [67:0] resp_vec(input int i);
        mem_resp_t [3:0] v;
        v    = '0;
        v[i] = mk_resp(i);
        return v;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        rstn           = 1'b0;
        mst_req_valid  = 4'hF;
        for (int i = 0; i < 4; i++) mst_req[i] = mk_req(i);
        mst_resp_ready = 4'hF;
        sn_req_ready   = 1'b1;
        sn_resp_valid  = 1'b1;
        sn_resp        = mk_resp(0);
        step(); step(); settle();
        chk("rst_sn_req_valid",   128'(sn_req_valid),   128'(0));
        chk("rst_mst_req_ready",  128'(mst_req_ready),  128'(0));
        chk("rst_mst_resp_valid", 128'(mst_resp_valid), 128'(0));
        chk("rst_sn_resp_ready",  128'(sn_resp_ready),  128'(0));
        chk("rst_outstd_cnt",     128'(outstd_cnt),     128'(0));
        chk("rst_resp_err",       128'(resp_err),       128'(0));
        sn_resp_valid = 1'b0;
        mst_req_valid = 4'h0;
        step();
        rstn = 1'b1;

        // ------- all masters busy, 1-cycle responses: grants 0,1,2,3,0 -------
        mst_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            sn_resp_valid = (k > 0);
            sn_resp       = mk_resp((k + 3) % 4);
            settle();
            chk("rr_sn_req_valid",   128'(sn_req_valid),   128'(1));
            chk("rr_sn_req",         128'(sn_req),         128'(mk_req(k % 4)));
            chk("rr_mst_req_ready",  128'(mst_req_ready),  128'(onehot(k % 4)));
            chk("rr_outstd_cnt",     128'(outstd_cnt),     128'(k > 0));
            chk("rr_mst_resp_valid", 128'(mst_resp_valid), 128'((k > 0) ? onehot((k + 3) % 4) : 4'h0));
            if (k > 0) chk("rr_mst_resp", 128'(mst_resp), 128'(resp_vec((k + 3) % 4)));
            step();
        end
        // Last response drains; no master requests so sn_req is all-zero.
        mst_req_valid = 4'h0;
        sn_resp_valid = 1'b1;
        sn_resp       = mk_resp(0);
        settle();
        chk("idle_sn_req_valid",   128'(sn_req_valid),   128'(0));
        chk("idle_sn_req_zero",    128'(sn_req),         128'(0));
        chk("drain_mst_resp_valid",128'(mst_resp_valid), 128'(4'b0001));
        chk("drain_sn_resp_ready", 128'(sn_resp_ready),  128'(1));
        step();
        sn_resp_valid = 1'b0;

        // ------- grant lock: master 2 stalled for 3 cycles (rr_ptr = 1) -------
        mst_req_valid = 4'b0100;
        sn_req_ready  = 1'b0;
        settle();
        chk("lock_valid_c1",  128'(sn_req_valid),  128'(1));
        chk("lock_req_c1",    128'(sn_req),        128'(mk_req(2)));
        chk("lock_ready_c1",  128'(mst_req_ready), 128'(0));
        step();
        mst_req_valid = 4'b0101;
        settle();
        chk("lock_req_c2",    128'(sn_req),        128'(mk_req(2)));
        step();
        mst_req[2] = mk_alt(2);
        settle();
        chk("lock_valid_c3",  128'(sn_req_valid),  128'(1));
        chk("lock_req_c3",    128'(sn_req),        128'(mk_req(2)));
        step();
        sn_req_ready = 1'b1;
        settle();
        chk("lock_req_hs",    128'(sn_req),        128'(mk_req(2)));
        chk("lock_ready_hs",  128'(mst_req_ready), 128'(4'b0100));
        step();
        mst_req_valid = 4'b0001;
        mst_req[2]    = mk_req(2);
        settle();
        chk("after_lock_req",   128'(sn_req),        128'(mk_req(0)));
        chk("after_lock_ready", 128'(mst_req_ready), 128'(4'b0001));
        chk("after_lock_cnt",   128'(outstd_cnt),    128'(1));
        step();
        // Queue holds [2,0]; master 2 back-pressures its response first.
        mst_req_valid  = 4'h0;
        sn_resp_valid  = 1'b1;
        sn_resp        = mk_resp(2);
        mst_resp_ready = 4'b1011;
        settle();
        chk("bp_cnt",            128'(outstd_cnt),     128'(2));
        chk("bp_sn_resp_ready",  128'(sn_resp_ready),  128'(0));
        chk("bp_mst_resp_valid", 128'(mst_resp_valid), 128'(4'b0100));
        step();
        mst_resp_ready = 4'hF;
        settle();
        chk("bp_cnt_held",       128'(outstd_cnt),     128'(2));
        chk("bp_sn_resp_ready1", 128'(sn_resp_ready),  128'(1));
        chk("bp_mst_resp",       128'(mst_resp),       128'(resp_vec(2)));
        step();
        sn_resp = mk_resp(0);
        settle();
        chk("ord_mst_resp_valid", 128'(mst_resp_valid), 128'(4'b0001));
        chk("ord_cnt",            128'(outstd_cnt),     128'(1));
        step();
        sn_resp_valid = 1'b0;
        settle();
        chk("drained_cnt", 128'(outstd_cnt), 128'(0));

        // ------- fill to MAX_OUTSTD (rr_ptr = 1): grants 1,2,3,0 -------
        mst_req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("fill_req", 128'(sn_req),     128'(mk_req((k + 1) % 4)));
            chk("fill_cnt", 128'(outstd_cnt), 128'(k));
            step();
        end
        settle();
        chk("full_sn_req_valid",  128'(sn_req_valid),  128'(0));
        chk("full_mst_req_ready", 128'(mst_req_ready), 128'(0));
        chk("full_cnt",           128'(outstd_cnt),    128'(4));
        step();
        settle();
        chk("full_cnt_hold",      128'(outstd_cnt),    128'(4));
        chk("full_valid_hold",    128'(sn_req_valid),  128'(0));
        // Response while full: space appears only from the next cycle.
        sn_resp_valid = 1'b1;
        sn_resp       = mk_resp(1);
        settle();
        chk("fullpop_sn_req_valid", 128'(sn_req_valid),   128'(0));
        chk("fullpop_resp_valid",   128'(mst_resp_valid), 128'(4'b0010));
        chk("fullpop_cnt",          128'(outstd_cnt),     128'(4));
        step();
        // Simultaneous push/pop across pointer wrap: heads 2,3,0,1,2.
        for (int k = 0; k < 5; k++) begin
            sn_resp = mk_resp((k + 2) % 4);
            settle();
            chk("wrap_sn_req_valid", 128'(sn_req_valid),   128'(1));
            chk("wrap_sn_req",       128'(sn_req),         128'(mk_req((k + 1) % 4)));
            chk("wrap_resp_valid",   128'(mst_resp_valid), 128'(onehot((k + 2) % 4)));
            chk("wrap_mst_resp",     128'(mst_resp),       128'(resp_vec((k + 2) % 4)));
            chk("wrap_cnt",          128'(outstd_cnt),     128'(3));
            step();
        end
        mst_req_valid = 4'h0;
        sn_resp_valid = 1'b0;
        settle();
        chk("pre_rst_cnt", 128'(outstd_cnt), 128'(3));

        // ------- reset with 3 outstanding -------
        rstn          = 1'b0;
        sn_resp_valid = 1'b1;
        sn_resp       = mk_resp(3);
        mst_req_valid = 4'hF;
        settle();
        chk("midrst_cnt",         128'(outstd_cnt),     128'(0));
        chk("midrst_sn_req_valid",128'(sn_req_valid),   128'(0));
        chk("midrst_resp_valid",  128'(mst_resp_valid), 128'(0));
        chk("midrst_resp_ready",  128'(sn_resp_ready),  128'(0));
        step();
        mst_req_valid = 4'h0;
        rstn          = 1'b1;
        // Stray response on an empty queue: dropped, flagged.
        settle();
        chk("stray_resp_valid",  128'(mst_resp_valid), 128'(0));
        chk("stray_resp_ready",  128'(sn_resp_ready),  128'(1));
        chk("stray_err_before",  128'(resp_err),       128'(0));
        step();
        sn_resp_valid = 1'b0;
        settle();
        chk("stray_err_set",     128'(resp_err),       128'(1));
        mst_req_valid = 4'hF;
        settle();
        chk("post_rst_req",      128'(sn_req),         128'(mk_req(0)));
        chk("post_rst_ready",    128'(mst_req_ready),  128'(4'b0001));
        step();
        mst_req_valid = 4'h0;
        settle();
        chk("stray_err_sticky",  128'(resp_err),       128'(1));
        rstn = 1'b0;
        settle();
        chk("rst_clears_err",    128'(resp_err),       128'(0));
        chk("rst_clears_cnt",    128'(outstd_cnt),     128'(0));
        step();
        rstn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_noc_rr_arb
`default_nettype wire
